// File: rtl/wb_traffic_master.sv
// Wishbone classic-cycle traffic initiator issuing a bounded run of LFSR-driven single reads/writes.
// Optional read-data check against the address-decoded slave index: `define WB_TRAFFIC_CHECK_EN.
module wb_traffic_master #(
    parameter logic [31:0] id      = 32'd0,
    parameter logic [15:0] n       = 16'd16,
    parameter logic [31:0] seed    = 32'h1,
    parameter logic [15:0] timeout = 16'd64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] timeout_count,
    output logic [15:0] err_count,
    output logic [31:0] dat_w,
    input  logic [31:0] dat_r,
    output logic [31:0] adr,
    output logic        we,
    output logic [3:0]  sel,
    output logic        cyc,
    output logic        stb,
    input  logic        ack
);

    localparam logic [2:0]  S_IDLE    = 3'd0;
    localparam logic [2:0]  S_LOAD    = 3'd1;
    localparam logic [2:0]  S_ISSUE   = 3'd2;
    localparam logic [2:0]  S_GAP     = 3'd3;
    localparam logic [2:0]  S_DONE    = 3'd4;
    localparam logic [31:0] POLY      = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF  = (seed == 32'd0) ? 32'd1 : seed;
    localparam logic [15:0] WAIT_LAST = timeout - 16'd1;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ({1'b0, l[31:1]} ^ POLY) : {1'b0, l[31:1]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d, lfsr_nx_s;
    logic [31:0] adr_q, adr_d, dat_w_q, dat_w_d;
    logic        we_q, we_d, cyc_q, cyc_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d, err_cnt_q, err_cnt_d;
    logic [15:0] wait_q, wait_d, retired_q, retired_d;
    logic [1:0]  gap_q, gap_d;
    logic        chk_err_s;
    logic        unused_s;

    assign lfsr_nx_s = lfsr_step(lfsr_q);
    assign unused_s  = ^dat_r;

`ifdef WB_TRAFFIC_CHECK_EN
    assign chk_err_s = ~we_q & (dat_r[15:0] != {12'h000, adr_q[31:28]});
`else
    assign chk_err_s = 1'b0;
`endif

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        adr_d     = adr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        dat_w_d   = dat_w_q;
        cyc_d     = cyc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        err_cnt_d = err_cnt_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        gap_d     = gap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tmo_cnt_d = 16'd0;
                    err_cnt_d = 16'd0;
                    retired_d = 16'd0;
                    busy_d    = 1'b1;
                    state_d   = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            // Single cyc-low cycle where the LFSR steps and the new bus fields are registered.
            S_LOAD: begin
                lfsr_d  = lfsr_nx_s;
                adr_d   = {lfsr_nx_s[31:2], 2'b00};
                we_d    = lfsr_nx_s[0];
                sel_d   = (lfsr_nx_s[7:4] == 4'h0) ? 4'hF : lfsr_nx_s[7:4];
                dat_w_d = {lfsr_nx_s[31:4], id[3:0]};
                cyc_d   = 1'b1;
                wait_d  = 16'd0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (ack) begin
                    cyc_d     = 1'b0;
                    retired_d = retired_q + 16'd1;
                    gap_d     = lfsr_q[9:8];
                    err_cnt_d = chk_err_s ? sat_inc(err_cnt_q) : err_cnt_q;
                    state_d   = S_GAP;
                end else if (wait_q == WAIT_LAST) begin
                    cyc_d     = 1'b0;
                    retired_d = retired_q + 16'd1;
                    gap_d     = lfsr_q[9:8];
                    tmo_cnt_d = sat_inc(tmo_cnt_q);
                    state_d   = S_GAP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_q != 2'd0) begin
                    gap_d = gap_q - 2'd1;
                end else if (retired_q == n) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Register update; reset drops the bus immediately and restores the seed.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_EFF;
            adr_q     <= 32'd0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            dat_w_q   <= 32'd0;
            cyc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_cnt_q <= 16'd0;
            err_cnt_q <= 16'd0;
            wait_q    <= 16'd0;
            retired_q <= 16'd0;
            gap_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            dat_w_q   <= dat_w_d;
            cyc_q     <= cyc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_cnt_q <= err_cnt_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            gap_q     <= gap_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_count = tmo_cnt_q;
    assign err_count     = err_cnt_q;
    assign dat_w         = dat_w_q;
    assign adr           = adr_q;
    assign we            = we_q;
    assign sel           = sel_q;
    assign cyc           = cyc_q;
    assign stb           = cyc_q;

endmodule

// File: doc/wb_traffic_master.md
# wb_traffic_master

Synthesizable Wishbone classic-cycle initiator that generates a bounded stream of pseudo-random single read/write transactions, driven by a 32-bit LFSR, for exercising `wb_intercon` arbitration and decoding in simulation and on FPGA. It occupies a master port of the interconnect, opposite the slave models. It reports completion, timeouts and, optionally, read-data check errors.

## Interface
- `id`, 0: master identifier, 4 bits used; echoed in `dat_w[3:0]`.
- `n`, 16: transactions per run, 1..65535.
- `seed`, 32'h1: LFSR seed, must be nonzero (zero is replaced by 32'h1).
- `timeout`, 64: cycles to wait for `ack` before abandoning a cycle, 2..65535.

- `sys_clk` in 1: clock, all logic on rising edge.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse begins a run; ignored unless idle.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse after the last transaction retires.
- `timeout_count` out 16: abandoned cycles this run.
- `err_count` out 16: read check mismatches this run.
- `dat_w` out 32, `dat_r` in 32, `adr` out 32, `we` out 1, `sel` out 4, `cyc` out 1, `stb` out 1, `ack` in 1: Wishbone master side.

## Operation
- Reset: all outputs 0; LFSR = `seed`; state IDLE; counters 0.
- LFSR: Galois, polynomial 0x80200003, advances exactly once per issued transaction, at entry to ISSUE. Sequence continues across runs (not reseeded by `start`).
- Fields from the new LFSR value L: `adr` = {L[31:2], 2'b00}; `we` = L[0]; `sel` = L[7:4], or 4'hF if L[7:4] = 0; `dat_w` = {L[31:4], id[3:0]}; gap = L[9:8].
- States:
  - IDLE: `start` → clear `timeout_count`, `err_count`, transaction counter; `busy` = 1; → ISSUE.
  - ISSUE: `cyc` = `stb` = 1, bus outputs held stable. `ack` sampled high → retire; → GAP. Wait counter reaching `timeout` → `timeout_count` +1 (saturating at 16'hFFFF), retire; → GAP.
  - GAP: `cyc` = `stb` = 0 for gap+1 cycles (1..4). Then, if retired count = `n` → DONE, else → ISSUE.
  - DONE: `done` = 1 for one cycle, `busy` = 0; → IDLE.
- `ack` outside ISSUE is ignored. `dat_r` is sampled only on the `ack` cycle of a read.
- `adr`, `we`, `sel`, `dat_w` keep their last values in GAP/IDLE; only `cyc`/`stb` signal validity.
- Reset asserted mid-run: bus released immediately (`cyc`/`stb` low), no `done`, LFSR back to `seed`.

## Timing
- `start` at edge k → `cyc`/`stb` high after edge k+1.
- `ack` high at edge m → `cyc`/`stb` low after edge m; next `cyc` no earlier than after edge m+2.
- Timeout: `cyc` dropped after the `timeout`-th cycle high without `ack`.
- `done` pulses the cycle after the final GAP; `busy` falls with it.
- Minimum transaction period with zero-wait `ack`: 3 cycles.

## Configuration
- `WB_TRAFFIC_CHECK_EN` defined: on every acknowledged read, `dat_r[15:0]` is compared with {12'h0, `adr[31:28]`} (the address-decoded slave index); a mismatch increments `err_count` (saturating).
- Undefined: no compare logic; `err_count` is constant 0.

## Test plan
- Reset with `seed` = 1, no `start` → all outputs 0 for 100 cycles; `start` pulse → first `adr` = 32'h80200000 (LFSR 0x80200003 after one step), `we` = 1, `sel` = 4'hF.
- Responder acking 1 cycle after every `stb`, `n` = 16 → exactly 16 `ack`-terminated cycles, `done` once, `timeout_count` = 0, `busy` low after.
- Responder never acks, `timeout` = 8, `n` = 3 → each `cyc` lasts 8 cycles, `timeout_count` = 3, `done` pulses.
- Check enabled, responder returns `dat_r[15:0]` = `adr[31:28]` except one read returning 16'hBEEF → `err_count` = 1.
- `sys_rst_n` low during ISSUE → `cyc`/`stb` fall asynchronously, no `done`; restart reproduces the same first `adr` as the first run.
- `start` pulsed while `busy` → ignored; transaction count still `n`.
